// File: rtl/fp_addsub_param.sv
// fp_addsub_param: parameterised IEEE-754 adder/subtractor, one operation at a
// time, fixed 5-cycle latency on the arithmetic path, 1 cycle for specials.
// Build option: define FPADD_DENORM_EN for subnormal support; without it,
// subnormal inputs read as zero and tiny results flush to zero.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [2:0]             out_flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;          // significand + guard/round/sticky
  localparam int EW   = EXP_W + 2;          // signed internal exponent
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SPEC, ALIGN, ADD, NORM, RND, OUT} state_t;
  state_t state_q, state_d;

  logic [W-1:0]          a_q, b_q, z_q;
  logic [2:0]            fl_q;
  logic                  xs_q, ys_q, zero_q;
  logic signed [EW-1:0]  xe_q, ye_q, e_q;
  logic [MAN_W:0]        xm_q, ym_q;
  logic [SW-1:0]         xa_q, ya_q, nm_q;
  logic [SW:0]           sum_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_z     = z_q;
  assign out_flags = fl_q;

  // Unpack operands and resolve NaN/inf/zero cases; order the pair by magnitude.
  logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             special, spec_inv, a_gt;
  logic [EXP_W-1:0] a_e, b_e, a_ee, b_ee;
  logic [MAN_W-1:0] a_f, b_f;
  logic [MAN_W:0]   a_m, b_m;
  logic [W-1:0]     spec_z;
  always_comb begin
    a_s = a_q[W-1]; a_e = a_q[W-2:MAN_W]; a_f = a_q[MAN_W-1:0];
    b_s = b_q[W-1]; b_e = b_q[W-2:MAN_W]; b_f = b_q[MAN_W-1:0];
    a_nan = (&a_e) && (|a_f);   a_inf = (&a_e) && !(|a_f);
    b_nan = (&b_e) && (|b_f);   b_inf = (&b_e) && !(|b_f);
`ifdef FPADD_DENORM_EN
    a_zero = (a_e == '0) && (a_f == '0);
    b_zero = (b_e == '0) && (b_f == '0);
    a_m  = {|a_e, a_f};
    b_m  = {|b_e, b_f};
    a_ee = (a_e == '0) ? EXP_W'(1) : a_e;
    b_ee = (b_e == '0) ? EXP_W'(1) : b_e;
`else
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_m  = {1'b1, a_f};
    b_m  = {1'b1, b_f};
    a_ee = a_e;
    b_ee = b_e;
`endif
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_z   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      spec_z   = QNAN;
      spec_inv = 1'b1;
    end
    else if (a_inf)             spec_z = a_q;
    else if (b_inf)             spec_z = b_q;
    else if (a_zero && b_zero)  spec_z = {a_s & b_s, {(W-1){1'b0}}};
    else if (a_zero)            spec_z = b_q;
    else if (b_zero)            spec_z = a_q;
    else                        special = 1'b0;
    // Raw exponent:mantissa compare orders magnitudes, subnormals included.
    a_gt = (a_q[W-2:0] >= b_q[W-2:0]);
  end

  // Barrel-align the smaller operand; everything pushed past R folds into sticky.
  int            al_d, al_sh;
  logic [2*SW-1:0] al_ext;
  logic [SW-1:0] al_y;
  always_comb begin
    al_d   = int'(xe_q) - int'(ye_q);
    al_sh  = (al_d > SW) ? SW : al_d;
    al_ext = {ym_q, 3'b000, {SW{1'b0}}} >> al_sh;
    al_y   = {al_ext[2*SW-1:SW+1], al_ext[SW] | (|al_ext[SW-1:0])};
  end

  // Magnitude add or subtract; x is never smaller than y so no borrow occurs.
  logic [SW:0] ad_sum;
  always_comb begin
    ad_sum = (xs_q == ys_q) ? ({1'b0, xa_q} + {1'b0, ya_q})
                            : ({1'b0, xa_q} - {1'b0, ya_q});
  end

  // Normalise: carry shifts right, otherwise left by LZC capped at exponent 1.
  int                   lz, nsh;
  logic [SW-1:0]        nm_d;
  logic signed [EW-1:0] ne_d;
  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (sum_q[i]) lz = SW - 1 - i;
    nsh = (lz > int'(xe_q) - 1) ? int'(xe_q) - 1 : lz;
    if (sum_q[SW]) begin
      nm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      ne_d = EW'(int'(xe_q) + 1);
    end else begin
      nm_d = sum_q[SW-1:0] << nsh;
      ne_d = EW'(int'(xe_q) - nsh);
    end
  end

  // Round to nearest even, then pack with overflow / underflow handling.
  logic [MAN_W+1:0] rm;
  int               re;
  logic             g, r, s, inc;
  logic [W-1:0]     rnd_z;
  logic [2:0]       rnd_f;
  always_comb begin
    g   = nm_q[2];
    r   = nm_q[1];
    s   = nm_q[0];
    inc = g & (r | s | nm_q[3]);
    rm  = {1'b0, nm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    re  = int'(e_q);
    if (rm[MAN_W+1]) begin
      rm = rm >> 1;
      re = re + 1;
    end
    rnd_z = {xs_q, EXP_W'(re), rm[MAN_W-1:0]};
    rnd_f = {2'b00, g | r | s};
`ifdef FPADD_DENORM_EN
    // Hidden bit still clear at exponent 1 means a subnormal: exponent field 0.
    if (!rm[MAN_W]) rnd_z[W-2:MAN_W] = '0;
`else
    if (!nm_q[SW-1]) begin
      rnd_z = {xs_q, {(W-1){1'b0}}};
      rnd_f = 3'b001;
    end
`endif
    if (re >= EMAX) begin
      rnd_z = {xs_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_f = 3'b011;
    end
    if (zero_q) begin
      rnd_z = '0;
      rnd_f = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one stage per cycle, specials bypass straight to OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SPEC;
      SPEC:    state_d = special ? OUT : ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = RND;
      RND:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, each loaded only in the stage that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q  <= '0;
      fl_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= in_a;
          b_q <= {in_b[W-1] ^ in_sub, in_b[W-2:0]};
        end
        SPEC: begin
          if (special) begin
            z_q  <= spec_z;
            fl_q <= {spec_inv, 2'b00};
          end
          xs_q <= a_gt ? a_s : b_s;
          ys_q <= a_gt ? b_s : a_s;
          xe_q <= a_gt ? {2'b00, a_ee} : {2'b00, b_ee};
          ye_q <= a_gt ? {2'b00, b_ee} : {2'b00, a_ee};
          xm_q <= a_gt ? a_m : b_m;
          ym_q <= a_gt ? b_m : a_m;
        end
        ALIGN: begin
          xa_q <= {xm_q, 3'b000};
          ya_q <= al_y;
        end
        ADD:  sum_q <= ad_sum;
        NORM: begin
          nm_q   <= nm_d;
          e_q    <= ne_d;
          zero_q <= (sum_q == '0);
        end
        RND: begin
          z_q  <= rnd_z;
          fl_q <= rnd_f;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: directed vectors, backpressure, mid-op reset,
// a half-precision instance, and random binary32 traffic against an
// exact-arithmetic reference model.
module tb_fp_addsub_param;
  logic        clk, rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_z;
  logic [2:0]  out_flags;
  logic        h_valid, h_ready, h_sub, h_ovalid, h_oready;
  logic [15:0] h_a, h_b, h_z;
  logic [2:0]  h_f;
  int checks = 0;
  int errors = 0;

  fp_addsub_param u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags));

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_h (
    .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
    .in_a(h_a), .in_b(h_b), .in_sub(h_sub), .out_valid(h_ovalid),
    .out_ready(h_oready), .out_z(h_z), .out_flags(h_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact value of a binary32 sum on a 2^-149 grid, then rounded to nearest even.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] z, output logic [2:0] f, output logic spec);
    logic as_, bs_, an, bn, ai, bi, az, bz, s, up;
    logic [7:0] ae, be;
    logic [22:0] af, bf;
    logic [319:0] va, vb, mag, keep, rem, half;
    int p, e, sh;
    as_ = a[31]; ae = a[30:23]; af = a[22:0];
    bs_ = b[31] ^ sub; be = b[30:23]; bf = b[22:0];
    an = (ae == 8'hFF) && (af != 0); ai = (ae == 8'hFF) && (af == 0);
    bn = (be == 8'hFF) && (bf != 0); bi = (be == 8'hFF) && (bf == 0);
`ifdef FPADD_DENORM_EN
    az = (ae == 0) && (af == 0); bz = (be == 0) && (bf == 0);
`else
    az = (ae == 0); bz = (be == 0);
`endif
    spec = 1'b1; f = 3'b000; z = 32'h0;
    if (an || bn || (ai && bi && (as_ != bs_))) begin z = 32'h7FC00000; f = 3'b100; return; end
    if (ai) begin z = a; return; end
    if (bi) begin z = {bs_, b[30:0]}; return; end
    if (az && bz) begin z = {as_ & bs_, 31'd0}; return; end
    if (az) begin z = {bs_, b[30:0]}; return; end
    if (bz) begin z = a; return; end
    spec = 1'b0;
    va = 320'({ae != 0, af}) << ((ae == 0) ? 0 : int'(ae) - 1);
    vb = 320'({be != 0, bf}) << ((be == 0) ? 0 : int'(be) - 1);
    if (as_ == bs_)   begin mag = va + vb; s = as_; end
    else if (va > vb) begin mag = va - vb; s = as_; end
    else if (vb > va) begin mag = vb - va; s = bs_; end
    else begin z = 32'h0; return; end
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) begin
`ifdef FPADD_DENORM_EN
      z = {s, 8'd0, mag[22:0]};
`else
      z = {s, 31'd0}; f = 3'b001;
`endif
      return;
    end
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag - (keep << sh);
    half = (sh > 0) ? (320'd1 << (sh - 1)) : 320'd0;
    up   = (sh > 0) && ((rem > half) || ((rem == half) && keep[0]));
    f[0] = (rem != 0);
    keep = keep + 320'(up);
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) begin z = {s, 8'hFF, 23'd0}; f = 3'b011; return; end
    z = {s, e[7:0], keep[22:0]};
  endfunction

  // Issue one operation with out_ready high; report result and accept-to-valid cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] z, output logic [2:0] f, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    z = out_z; f = out_flags;
    @(posedge clk);
  endtask

  typedef struct { logic [31:0] a, b; logic sub; logic [31:0] z; logic [2:0] f; int lat; } vec_t;

  initial begin
    vec_t dv[$];
    logic [31:0] z, mz;
    logic [2:0]  f, mf;
    logic        ms;
    int          lat, hl;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    h_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_oready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_z", 64'(out_z), 64'd0);
    check("reset_flags", 64'(out_flags), 64'd0);
    rst = 1'b0;

    dv.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 5});
    dv.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 5});
    dv.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1});
    dv.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1});
    dv.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1});
    dv.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 5});
    dv.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 5});
    dv.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 5});
`ifdef FPADD_DENORM_EN
    dv.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 5});
`else
    dv.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000, 1});
`endif
    foreach (dv[k]) begin
      run_op(dv[k].a, dv[k].b, dv[k].sub, z, f, lat);
      check($sformatf("dir%0d_z", k), 64'(z), 64'(dv[k].z));
      check($sformatf("dir%0d_flags", k), 64'(f), 64'(dv[k].f));
      check($sformatf("dir%0d_latency", k), 64'(lat), 64'(dv[k].lat));
    end

    // Backpressure: result must sit still for 10 cycles, then one handshake.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("bp_latency", 64'(lat), 64'd5);
    repeat (10) begin
      check("bp_out_z", 64'(out_z), 64'h40400000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);

    // Reset while the operation is in ALIGN.
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_busy_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_z", 64'(out_z), 64'd0);
    repeat (6) @(negedge clk);
    check("rst_no_partial", 64'(out_valid), 64'd0);

    // Half-precision instance.
    h_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00; h_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
    hl = 0;
    while (!h_ovalid && hl < 40) begin @(negedge clk); hl++; end
    check("half_z", 64'(h_z), 64'h4000);
    check("half_flags", 64'(h_f), 64'd0);
    check("half_latency", 64'(hl), 64'd5);

    // Random binary32 traffic, exponents steered toward close, tiny and huge values.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      int ea, eb, r;
      logic sub;
      a = $urandom; b = $urandom; sub = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 2)       ea = int'($urandom_range(0, 4));
      else if (r == 2) ea = int'($urandom_range(250, 255));
      else             ea = int'($urandom_range(1, 254));
      case ($urandom_range(0, 7))
        0: eb = int'($urandom_range(0, 255));
        1: begin eb = ea; b[22:0] = a[22:0] ^ 23'($urandom_range(0, 15)); end
        default: begin
          eb = ea + int'($urandom_range(0, 56)) - 28;
          if (eb < 0) eb = 0;
          if (eb > 255) eb = 255;
        end
      endcase
      a[30:23] = 8'(ea);
      b[30:23] = 8'(eb);
      model(a, b, sub, mz, mf, ms);
      run_op(a, b, sub, z, f, lat);
      check($sformatf("rnd%0d_z a=%h b=%h sub=%0d", n, a, b, sub), 64'(z), 64'(mz));
      check($sformatf("rnd%0d_flags", n), 64'(f), 64'(mf));
      check($sformatf("rnd%0d_latency", n), 64'(lat), ms ? 64'd1 : 64'd5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
